// File: rtl/cla_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit carry-lookahead slice per clock,
// least significant nibble first, computed as a + ~b + ~bin with the carry chained across cycles.
module cla_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r, nb_r, res_r, res_nx;
   logic             carry, a_msb, b_msb;
   logic [IW-1:0]    idx;
   logic [3:0]       g, p, s;
   logic [4:0]       c;

   // Operand registers shift right each cycle, so the active nibble is always [3:0].
   always_comb begin
      g    = a_r[3:0] & nb_r[3:0];
      p    = a_r[3:0] ^ nb_r[3:0];
      c[0] = carry;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s    = p ^ c[3:0];
      res_nx = res_r >> 4;
      res_nx[WIDTH-1 -: 4] = s;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         a_r   <= '0;
         nb_r  <= '0;
         res_r <= '0;
         carry <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= a;
                  nb_r  <= ~b;
                  carry <= ~bin;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               a_r   <= a_r >> 4;
               nb_r  <= nb_r >> 4;
               res_r <= res_nx;
               carry <= c[4];
               idx   <= idx + 1'b1;
               if (idx == IW'(NIB - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  diff  <= res_nx;
                  bout  <= ~c[4];
                  ovf   <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
                  state <= DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Bench for cla_serial_subtractor: directed literal cases plus random traffic checked
// every cycle against an arithmetic model with a cycle-countdown handshake.
module tb_cla_serial_subtractor;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk, rst_n, start, bin;
   logic [W-1:0] a, b;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;

   int n_chk = 0;
   int n_err = 0;

   cla_serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // {ovf, bout, diff} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
      logic [W:0] full;
      int         sr;
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      return {(sr > 32767 || sr < -32768), full[W], full[W-1:0]};
   endfunction

   logic         m_valid = 1'b0;
   logic         m_busy, m_done, e_bout, e_ovf;
   logic [W-1:0] e_diff;
   logic [W+1:0] pend;
   int           m_cnt;

   always @(posedge clk) begin
      m_valid <= 1'b1;
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
         e_diff <= '0; e_bout <= 1'b0; e_ovf <= 1'b0;
      end else if (!m_busy && !m_done) begin
         if (start) begin
            pend   <= model(a, b, bin);
            m_cnt  <= NIB;
            m_busy <= 1'b1;
         end
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            {e_ovf, e_bout, e_diff} <= pend;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp busy", busy, m_busy);
         chk("cmp done", done, m_done);
         chk("cmp diff", diff, e_diff);
         chk("cmp bout", bout, e_bout);
         chk("cmp ovf",  ovf,  e_ovf);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one operation; with noise, start stays high and operands churn while busy/done.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input bit noise);
      int n;
      a = ta; b = tb_b; bin = tbin; start = 1'b1;
      tick;
      start = noise;
      n = 0;
      while (!done && n < 20) begin
         if (noise) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         end
         tick;
         n++;
      end
      chk("latency", n, NIB);
      chk("diff", diff, ed);
      chk("bout", bout, eb);
      chk("ovf", ovf, eo);
      chk("busy at done", busy, 1'b0);
      tick;
      start = 1'b0;
      chk("diff hold", diff, ed);
      chk("done width", done, 1'b0);
   endtask

   initial begin
      int dcnt;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      tick;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset diff", diff, 16'h0000);

      run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
      run_op(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
      run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

      // abort during the second busy cycle
      a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort diff", diff, 16'h0000);
      chk("abort bout", bout, 1'b0);
      chk("abort ovf",  ovf,  1'b0);
      dcnt = 0;
      repeat (8) begin
         tick;
         if (done) dcnt++;
      end
      chk("abort no done", dcnt, 0);
      run_op(16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0);

      // start held high: one accepted operation per NIB+2 cycles
      start = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 36; k++) begin
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         tick;
         if (done) dcnt++;
      end
      start = 1'b0;
      chk("held start ops", dcnt, 6);
      repeat (8) tick;

      for (int k = 0; k < 600; k++) begin
         start = ($urandom_range(0, 2) == 0);
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         if ($urandom_range(0, 3) == 0) a = b;
         rst_n = ($urandom_range(0, 59) != 0);
         tick;
      end
      rst_n = 1'b1; start = 1'b0;
      repeat (10) tick;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
